// File: rtl/msrr8dff_if.sv
// msrr8dff_if: groups the data-path signals of the multi-mode shift register.
//
// Signals
//   sel  [1:0]        mode select, sampled at the rising clock edge
//   Sin               serial data in, sampled at the rising clock edge
//   Po   [WIDTH-1:0]  parallel output, a direct copy of the register state
//
// Handshake: none. sel and Sin are plain level inputs. Only their values at
// the rising clock edge matter, and Po is valid one clock after that edge.
//
// Modports
//   master : the side that drives sel/Sin and observes Po (e.g. a testbench)
//   slave  : the shift register itself
interface msrr8dff_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       sel;
    logic             Sin;
    logic [WIDTH-1:0] Po;

    modport master (
        output sel,
        output Sin,
        input  Po
    );

    modport slave (
        input  sel,
        input  Sin,
        output Po
    );
endinterface

// File: rtl/msrr8dff.sv
// msrr8dff: WIDTH-bit multi-mode shift register (default 8 bits).
//
// Every rising clock edge applies one of four operations chosen by sel:
//   00 hold          Q_next = Q
//   01 shift right   Q_next = {Sin, Q[W-1:1]}   (LSB discarded)
//   10 shift left    Q_next = {Q[W-2:0], Sin}   (MSB discarded)
//   11 rotate right  Q_next = {Q[0], Q[W-1:1]}  (Sin ignored)
//
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-low reset; clears the register immediately
//   bus  msrr8dff_if.slave carrying sel, Sin (in) and Po (out)
//
// Po is the register itself: there is no combinational path from sel or
// Sin to Po, and the latency from an edge to Po is exactly one clock.
module msrr8dff #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    msrr8dff_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_ROR  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    mode_e            mode;

    assign mode = mode_e'(bus.sel);

    always_comb begin
        q_next = q;
        case (mode)
            MODE_HOLD: q_next = q;
            MODE_SHR:  q_next = {bus.Sin, q[WIDTH-1:1]};
            MODE_SHL:  q_next = {q[WIDTH-2:0], bus.Sin};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            // An unknown select lets X reach the register; a later reset
            // always restores a fully known state.
            default:   q_next = 'x;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

    assign bus.Po = q;

endmodule

// File: tb/tb_msrr8dff.sv
module tb_msrr8dff;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    msrr8dff_if #(.WIDTH(W)) bus ();

    msrr8dff #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int tests;
    int fails;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: Po=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference, written directly from the mode table.
    function automatic logic [W-1:0] model_next(input logic [W-1:0] q, input logic [1:0] s, input logic si);
        case (s)
            2'b00:   return q;
            2'b01:   return {si, q[W-1:1]};
            2'b10:   return {q[W-2:0], si};
            default: return {q[0], q[W-1:1]};
        endcase
    endfunction

    // ---------------- driver ----------------
    // Drive inputs at the falling edge, push the expectation, then pop and
    // compare 1 ns after the following rising edge.
    task automatic do_edge(input logic rst_v, input logic [1:0] s, input logic si,
                           input logic [W-1:0] exp, input string name);
        logic [W-1:0] e;
        @(negedge clk);
        rst = rst_v;
        bus.sel = s;
        bus.Sin = si;
        if (!rst_v) begin
            #1;
            check({name, "_async"}, bus.Po, '0);
        end
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, bus.Po, e);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]   sel;
        logic         sin;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] s, input logic si, input logic [W-1:0] e);
        vec_t v;
        v.sel = s;
        v.sin = si;
        v.exp = e;
        vecs.push_back(v);
    endtask

    logic [W-1:0] mq;
    logic [7:0] tmp;

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        bus.sel = 2'b01;
        bus.Sin = 1'b1;

        // Reset state: held in reset across edges with active inputs.
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", bus.Po, 8'h00);

        // Table: shift-right fill, shift-left build of 81, rotate, hold,
        // shift-left build of 0F, then a mode switch burst.
        add(2'b01, 1, 8'h80); add(2'b01, 1, 8'hC0); add(2'b01, 1, 8'hE0); add(2'b01, 1, 8'hF0);
        add(2'b01, 1, 8'hF8); add(2'b01, 1, 8'hFC); add(2'b01, 1, 8'hFE); add(2'b01, 1, 8'hFF);
        add(2'b01, 0, 8'h7F);
        add(2'b10, 1, 8'hFF); add(2'b10, 0, 8'hFE); add(2'b10, 0, 8'hFC); add(2'b10, 0, 8'hF8);
        add(2'b10, 0, 8'hF0); add(2'b10, 0, 8'hE0); add(2'b10, 0, 8'hC0); add(2'b10, 1, 8'h81);
        add(2'b11, 0, 8'hC0); add(2'b11, 1, 8'h60); add(2'b11, 0, 8'h30); add(2'b11, 1, 8'h18);
        add(2'b11, 0, 8'h0C); add(2'b11, 1, 8'h06); add(2'b11, 0, 8'h03); add(2'b11, 1, 8'h81);
        add(2'b00, 1, 8'h81); add(2'b00, 0, 8'h81); add(2'b00, 1, 8'h81); add(2'b00, 0, 8'h81);
        add(2'b00, 1, 8'h81);
        add(2'b10, 0, 8'h02); add(2'b10, 0, 8'h04); add(2'b10, 0, 8'h08); add(2'b10, 0, 8'h10);
        add(2'b10, 1, 8'h21); add(2'b10, 1, 8'h43); add(2'b10, 1, 8'h87); add(2'b10, 1, 8'h0F);
        add(2'b01, 0, 8'h07); add(2'b10, 1, 8'h0F); add(2'b11, 1, 8'h87);

        for (int i = 0; i < vecs.size(); i++) begin
            do_edge(1'b1, vecs[i].sel, vecs[i].sin, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Async reset: load A5 by shifting left, then clear mid-cycle.
        tmp = 8'hA5;
        mq = 8'h87;
        for (int i = 7; i >= 0; i--) begin
            mq = model_next(mq, 2'b10, tmp[i]);
            do_edge(1'b1, 2'b10, tmp[i], mq, "load_a5");
        end
        check("load_a5_done", bus.Po, 8'hA5);
        #2;
        rst = 1'b0;
        #1;
        check("async_clear", bus.Po, 8'h00);
        for (int i = 0; i < 3; i++) begin
            do_edge(1'b0, 2'b01, 1'b1, 8'h00, "reset_hold");
        end

        // Release, then shift left 1,0,1,1 from zero.
        do_edge(1'b1, 2'b10, 1'b1, 8'h01, "shl_a");
        do_edge(1'b1, 2'b10, 1'b0, 8'h02, "shl_b");
        do_edge(1'b1, 2'b10, 1'b1, 8'h05, "shl_c");
        do_edge(1'b1, 2'b10, 1'b1, 8'h0B, "shl_d");

        // Random soak against the model, with occasional resets.
        mq = 8'h0B;
        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic [1:0] s;
            logic       si;
            r  = ($urandom_range(0, 19) != 0);
            s  = 2'($urandom_range(0, 3));
            si = 1'($urandom_range(0, 1));
            mq = r ? model_next(mq, s, si) : '0;
            do_edge(r, s, si, mq, "soak");
        end

        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL leftover: %0d expectations not consumed", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/msrr8dff.md
Name: msrr8dff

Overview:
- 8-bit multi-mode shift register built from edge-triggered D flip-flops, with 1-bit serial input and 8-bit parallel output.
- A 2-bit select chooses hold, shift right, shift left or rotate right on each rising clock edge.
- Used as a serial-to-parallel converter / scratch shifter in the datapath; a single clock domain.

Parameters:
- WIDTH, 8, register length in bits. Ports and behaviour below are written for 8; all rules scale with WIDTH.

Ports:
- clk  input  1  clock; the register updates on the rising edge.
- rst  input  1  asynchronous active-low reset; 0 clears the register immediately.
- sel  input  2  mode select, sampled at the rising edge of clk.
- Sin  input  1  serial data in, sampled at the rising edge of clk.
- Po   output 8  parallel output; a direct copy of the register state Q[7:0].

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-low.
- Reset:
  - When rst=0, Q=8'h00 immediately, independent of clk. Po follows with no clock needed.
  - While rst=0, the register holds 8'h00 and ignores clk, sel and Sin.
  - Release: rst 0->1 takes effect at the next rising clk edge. The first edge after release updates normally from 8'h00.
  - If reset asserts mid-operation, the register clears at once. Shift progress is lost.
- Rising clk edge with rst=1, Q_next by sel:
  - 00: hold. Q_next = Q.
  - 01: shift right, serial in at MSB. Q_next = {Sin, Q[7:1]}. Q[0] is discarded.
  - 10: shift left, serial in at LSB. Q_next = {Q[6:0], Sin}. Q[7] is discarded.
  - 11: rotate right. Q_next = {Q[0], Q[7:1]}. Sin is ignored.
- Latency: exactly one clock. Po reflects the new state right after the edge, with no extra output register.
- sel and Sin may change at any time between edges. Only their values at the rising edge matter, with no handshake.
- sel changes between any two modes take effect on the next edge with no penalty cycle.
- Outputs are purely registered. Po has no combinational path from sel or Sin.
- Unknown inputs: X/Z on sel or Sin at an edge may propagate X into Q. After any reset, Po must be fully known (8'h00).
- Power-up before the first reset is undefined. The bench must apply rst=0 before checking.

Test Plan:
- Async reset: load Q=8'hA5, then pull rst=0 mid-cycle, away from any clk edge -> Po=8'h00 at once. Hold rst=0 across 3 edges with sel=01, Sin=1 -> Po stays 8'h00.
- Shift right fill: after reset, sel=01, Sin=1 for 8 edges -> Po steps 80,C0,E0,...,FF. Then Sin=0 for 1 edge -> 8'h7F.
- Shift left: from 8'h00, sel=10 with Sin sequence 1,0,1,1 over 4 edges -> Po=01,02,05,0B.
- Rotate and hold: from Q=8'h81, sel=11 for 1 edge -> 8'hC0; 8 edges total -> back to 8'h81 with Sin toggling throughout. Then sel=00 for 5 edges -> Po unchanged.
- Mode switch: from Q=8'h0F, one edge each of sel=01 (Sin=0), 10 (Sin=1), 11 -> Po=07,0F,87.
- Random soak: random sel/Sin/rst for 500+ cycles -> Po matches the behavioural model on every edge. Po=00 whenever rst=0.
